seq_det_word_ctrl: RTL and testbench
====================================

// Module: seq_det_word_ctrl
// PURPOSE
//  Word-level controller around the serial 110 / 11110 Mealy pattern detector.
//  - Accepts parallel words on a valid/ready input and shifts them MSB-first through an
//    internal detector instance, one bit per clock.
//  - Counts detector hits per word and returns the count on a valid/ready output.
//  - Sits between a bus-side producer and the bit-serial detector; owns its sequencing and state restarts.
// PARAMETERS
//  W      8  data word width in bits (>=2)
//  CNT_W  4  hit-count width; must satisfy 2**CNT_W-1 >= W
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  clear        in   1      synchronous abort: return to IDLE, detector to S0
//  cfg_restart  in   1      1: detector forced to S0 at the start of every word; 0: stream mode
//  in_valid     in   1      input word valid
//  in_ready     out  1      controller can accept a word (IDLE only)
//  in_data      in   W      input word, bit W-1 shifted first
//  hit          out  1      detector Mealy output, qualified by SHIFT state
//  busy         out  1      1 in SHIFT or DONE
//  out_valid    out  1      result valid
//  out_ready    in   1      result consumer ready
//  out_hits     out  CNT_W  number of hits in the word just processed
// BEHAVIOUR
//  Reset (rst_n=0, async): ctrl=IDLE, det=S0, shift reg=0, idx=0, count=0.
//   Outputs: in_ready=1, out_valid=0, out_hits=0, hit=0, busy=0.
//  Detector (states S0,S1,S11,S110,S111,S1111,S11110), written next-state / y for x=0 ; x=1:
//   S0: S0/0 ; S1/0       S1: S0/0 ; S11/0        S11: S110/1 ; S111/0
//   S110: S0/0 ; S1/0     S111: S0/0 ; S1111/0    S1111: S11110/1 ; S1/0
//   S11110: S0/0 ; S1/0
//   Detector advances only in SHIFT. It holds in IDLE and DONE.
//  Controller FSM:
//   IDLE: in_ready=1.
//    - On in_valid: latch in_data, idx<=W-1, count<=0, go to SHIFT.
//    - If cfg_restart=1 at acceptance, det<=S0 in the same edge.
//   SHIFT: x=shreg[idx] each cycle.
//    - hit=y; det<=next.
//    - If y, count<=count+1, saturating at 2**CNT_W-1.
//    - idx<=idx-1. The cycle with idx==0 is the last; go to DONE.
//   DONE: out_valid=1, out_hits=count, held stable until out_ready=1, then go to IDLE.
//    - out_valid and out_hits stay stable under backpressure.
//  Timing:
//   - Latency: word accepted at edge t; out_valid first high after edge t+W.
//   - Min period per word: W+2 cycles.
//   - hit is combinational from det state and the current bit; it is 0 outside SHIFT.
//   - out_hits is registered.
//  clear=1 (any state, priority over handshake):
//   - Next edge: IDLE, det=S0, count=0, idx=0, out_valid=0.
//   - Any in-flight or pending result is discarded, with no out_valid pulse.
//  Simultaneous events:
//   - clear together with in_valid in IDLE: word is NOT accepted (in_ready is still 1 that cycle;
//     the producer must treat clear as a flush).
//   - DONE with out_ready=1: returns to IDLE; a new word is accepted no earlier than the next cycle.
//  Stream mode (cfg_restart=0): detector state carries across words. A pattern split between
//   words is detected and counted in the word containing its final bit.
//  rst_n asserted mid-SHIFT: immediate return to reset values; the partial word is lost.
// TESTING (W=8, CNT_W=4, fresh reset unless noted)
//  1. Send 8'hD8 (1101_1000), restart=1 -> hit pulses on bits 2 and 5; out_hits=2 after 9 cycles.
//  2. Send 8'hF0, restart=1 -> hits=1 (11110 prefix).
//     Send 8'hF8 -> hits=0 (five 1s reset to S1, then 0 -> S0).
//  3. Stream mode: send 8'h03, then 8'h00 -> hits 0 then 1 (S11 carried over).
//     Repeat with restart=1 -> hits 0 then 0.
//  4. Backpressure: send 8'hD8, hold out_ready=0 for 5 cycles.
//     -> out_valid=1, out_hits=2 stable; in_ready=0 throughout; accepted after out_ready=1.
//  5. clear asserted at 4th SHIFT cycle of 8'hD8 -> next cycle IDLE, out_valid never rises.
//     Next word 8'hF0 -> hits=1.
//  6. rst_n low mid-SHIFT for 1 cycle -> all outputs at reset values asynchronously.
//     Back-to-back words afterwards -> one result every 10 cycles with out_ready=1.

Source files
------------

// File: rtl/seq_det_word_ctrl.sv
// Word-level controller: accepts parallel words, shifts them MSB-first through the
// 110 / 11110 Mealy detector and returns the per-word hit count on a valid/ready port.
module seq_det_word_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cfg_restart,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             hit,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_hits
);

  localparam int unsigned      IDX_W    = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    C_IDLE,
    C_SHIFT,
    C_DONE
  } ctrl_e;

  typedef enum logic [2:0] {
    S0,
    S1,
    S11,
    S110,
    S111,
    S1111,
    S11110
  } det_e;

  ctrl_e            ctrl_q, ctrl_d;
  det_e             det_q, det_d, det_nxt;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bit_x;
  logic             det_y;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= C_IDLE;
      det_q   <= S0;
      shreg_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      det_q   <= det_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Mealy detector transition and output for the bit currently addressed
  always_comb begin
    det_nxt = S0;
    det_y   = 1'b0;
    bit_x   = shreg_q[idx_q];
    case (det_q)
      S0:      det_nxt = bit_x ? S1 : S0;
      S1:      det_nxt = bit_x ? S11 : S0;
      S11: begin
        det_nxt = bit_x ? S111 : S110;
        det_y   = ~bit_x;
      end
      S110:    det_nxt = bit_x ? S1 : S0;
      S111:    det_nxt = bit_x ? S1111 : S0;
      S1111: begin
        det_nxt = bit_x ? S1 : S11110;
        det_y   = ~bit_x;
      end
      S11110:  det_nxt = bit_x ? S1 : S0;
      default: det_nxt = S0;
    endcase
  end

  // Controller next state; clear overrides every handshake
  always_comb begin
    ctrl_d  = ctrl_q;
    det_d   = det_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    count_d = count_q;
    if (clear) begin
      ctrl_d  = C_IDLE;
      det_d   = S0;
      idx_d   = '0;
      count_d = '0;
    end else begin
      case (ctrl_q)
        C_IDLE: begin
          if (in_valid) begin
            shreg_d = in_data;
            idx_d   = IDX_LAST;
            count_d = '0;
            ctrl_d  = C_SHIFT;
            if (cfg_restart) begin
              det_d = S0;
            end
          end
        end
        C_SHIFT: begin
          det_d = det_nxt;
          if (det_y && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
          end
          if (idx_q == '0) begin
            ctrl_d = C_DONE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        C_DONE: begin
          if (out_ready) begin
            ctrl_d = C_IDLE;
          end
        end
        default: ctrl_d = C_IDLE;
      endcase
    end
  end

  // Status decodes straight from registered state
  assign in_ready  = (ctrl_q == C_IDLE);
  assign busy      = (ctrl_q != C_IDLE);
  assign out_valid = (ctrl_q == C_DONE);
  assign out_hits  = count_q;
  assign hit       = (ctrl_q == C_SHIFT) & det_y;

endmodule

// File: tb/tb_seq_det_word_ctrl.sv
// Directed bench for seq_det_word_ctrl (W=8, CNT_W=4): one task per scenario, inline checks.
module tb_seq_det_word_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       cfg_restart;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       hit;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_hits;

  int n_checks = 0;
  int n_pass   = 0;

  seq_det_word_ctrl #(.W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_restart(cfg_restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hit(hit), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_hits(out_hits)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b1; cfg_restart = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offers one word, records hit per SHIFT cycle (MSB first) until out_valid; leaves DUT in DONE.
  task automatic run_word(input logic [7:0] w, output logic [3:0] hits,
                          output logic [7:0] mask, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; mask = 8'h00;
    while (!out_valid && lat < 20) begin
      mask = {mask[6:0], hit};
      lat++;
      @(negedge clk);
    end
    hits = out_hits;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b1; cfg_restart = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_hits !== 4'd0) $display("FAIL reset_out_hits got %0d exp 0", out_hits); else n_pass++;
    n_checks++; if (hit !== 1'b0) $display("FAIL reset_hit got %b exp 0", hit); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_d8();
    logic [3:0] h; logic [7:0] m; int lat;
    do_reset();
    run_word(8'hD8, h, m, lat);
    n_checks++; if (h !== 4'd2) $display("FAIL d8_hits got %0d exp 2", h); else n_pass++;
    n_checks++; if (m !== 8'h24) $display("FAIL d8_hit_mask got %h exp 24", m); else n_pass++;
    n_checks++; if (lat !== 8) $display("FAIL d8_latency got %0d exp 8", lat); else n_pass++;
    n_checks++; if (busy !== 1'b1 || hit !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL d8_done_flags got busy=%b hit=%b in_ready=%b exp 1 0 0", busy, hit, in_ready); else n_pass++;
  endtask

  task automatic test_f0_f8();
    logic [3:0] h; logic [7:0] m; int lat;
    do_reset();
    run_word(8'hF0, h, m, lat);
    n_checks++; if (h !== 4'd1) $display("FAIL f0_hits got %0d exp 1", h); else n_pass++;
    n_checks++; if (m !== 8'h08) $display("FAIL f0_hit_mask got %h exp 08", m); else n_pass++;
    run_word(8'hF8, h, m, lat);
    n_checks++; if (h !== 4'd0) $display("FAIL f8_hits got %0d exp 0", h); else n_pass++;
  endtask

  task automatic test_stream();
    logic [3:0] h; logic [7:0] m; int lat;
    do_reset();
    cfg_restart = 1'b0;
    run_word(8'h03, h, m, lat);
    n_checks++; if (h !== 4'd0) $display("FAIL stream_03_hits got %0d exp 0", h); else n_pass++;
    run_word(8'h00, h, m, lat);
    n_checks++; if (h !== 4'd1) $display("FAIL stream_00_hits got %0d exp 1", h); else n_pass++;
    n_checks++; if (m !== 8'h80) $display("FAIL stream_00_mask got %h exp 80", m); else n_pass++;
    do_reset();
    cfg_restart = 1'b1;
    run_word(8'h03, h, m, lat);
    n_checks++; if (h !== 4'd0) $display("FAIL restart_03_hits got %0d exp 0", h); else n_pass++;
    run_word(8'h00, h, m, lat);
    n_checks++; if (h !== 4'd0) $display("FAIL restart_00_hits got %0d exp 0", h); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0] h; logic [7:0] m; int lat;
    do_reset();
    out_ready = 1'b0;
    run_word(8'hD8, h, m, lat);
    n_checks++; if (h !== 4'd2) $display("FAIL bp_hits got %0d exp 2", h); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hF0;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_hits !== 4'd2)
        $display("FAIL bp_hold_%0d got valid=%b hits=%0d exp 1 2", i, out_valid, out_hits); else n_pass++;
      n_checks++; if (in_ready !== 1'b0 || hit !== 1'b0)
        $display("FAIL bp_in_ready_%0d got in_ready=%b hit=%b exp 0 0", i, in_ready, hit); else n_pass++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid); else n_pass++;
    run_word(8'hF0, h, m, lat);
    n_checks++; if (h !== 4'd1) $display("FAIL bp_next_hits got %0d exp 1", h); else n_pass++;
  endtask

  task automatic test_clear();
    logic [3:0] h; logic [7:0] m; int lat; logic seen;
    do_reset();
    cfg_restart = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hD8;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL clear_idle got in_ready=%b busy=%b exp 1 0", in_ready, busy); else n_pass++;
    n_checks++; if (out_hits !== 4'd0) $display("FAIL clear_count got %0d exp 0", out_hits); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL clear_no_result got %b exp 0", seen); else n_pass++;
    run_word(8'hF0, h, m, lat);
    n_checks++; if (h !== 4'd1) $display("FAIL clear_next_hits got %0d exp 1", h); else n_pass++;
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hD8;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clear_vs_valid got busy=%b in_ready=%b exp 0 1", busy, in_ready); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hD8;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || out_hits !== 4'd1)
      $display("FAIL arst_pre got busy=%b hits=%0d exp 1 1", busy, out_hits); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL arst_flags got in_ready=%b busy=%b out_valid=%b exp 1 0 0", in_ready, busy, out_valid); else n_pass++;
    n_checks++; if (out_hits !== 4'd0 || hit !== 1'b0)
      $display("FAIL arst_outputs got hits=%0d hit=%b exp 0 0", out_hits, hit); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t[3]; int n; int cyc;
    cfg_restart = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hD8;
    n = 0;
    for (cyc = 0; cyc < 35; cyc++) begin
      if (out_valid && n < 3) begin
        t[n] = cyc;
        n++;
        n_checks++; if (out_hits !== 4'd2) $display("FAIL b2b_hits_%0d got %0d exp 2", n, out_hits); else n_pass++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (n !== 3) $display("FAIL b2b_count got %0d exp 3", n); else n_pass++;
    if (n == 3) begin
      n_checks++; if (t[1] - t[0] !== 10) $display("FAIL b2b_period1 got %0d exp 10", t[1] - t[0]); else n_pass++;
      n_checks++; if (t[2] - t[1] !== 10) $display("FAIL b2b_period2 got %0d exp 10", t[2] - t[1]); else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_d8();
    test_f0_f8();
    test_stream();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
